// File: rtl/bit_serializer.sv
// Parallel-to-serial front end. Words arrive on a valid/ready handshake. A one-word hold
// buffer lets consecutive words stream out bit by bit with no idle cycle between them.
module bit_serializer #(
  parameter int NUM_BITS   = 8,
  parameter int MSB_FIRST  = 1,
  parameter int BIT_PERIOD = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] data_in,
  input  logic                load_valid,
  output logic                load_ready,
  output logic                serial_out,
  output logic                serial_valid,
  output logic                word_done,
  output logic                busy
);

  localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int DW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(BIT_PERIOD - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state, state_nxt;
  logic [NUM_BITS-1:0] shift_reg, shift_nxt;
  logic [NUM_BITS-1:0] hold_reg, hold_nxt;
  logic                hold_full, hold_full_nxt;
  logic [BW-1:0]       bit_cnt, bit_nxt, idx_nxt;
  logic [DW-1:0]       div_cnt, div_nxt;
  logic                serial_nxt;
  logic                accept;
  logic                last_tick;

  assign load_ready   = !hold_full;
  assign serial_valid = (state == SHIFT);
  assign busy         = serial_valid;
  assign word_done    = last_tick;

  assign accept    = load_valid && load_ready;
  assign last_tick = (state == SHIFT) && (bit_cnt == LAST_BIT) && (div_cnt == LAST_DIV);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned
    // (an unassigned path would infer a latch).
    state_nxt     = state;
    shift_nxt     = shift_reg;
    hold_nxt      = hold_reg;
    hold_full_nxt = hold_full;
    bit_nxt       = bit_cnt;
    div_nxt       = div_cnt;

    unique case (state)
      IDLE: begin
        if (accept) begin
          shift_nxt = data_in;
          bit_nxt   = '0;
          div_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last_tick) begin
          bit_nxt = '0;
          div_nxt = '0;
          // Refill from the hold buffer first; a direct load is only possible when it is empty.
          if (hold_full) begin
            shift_nxt     = hold_reg;
            hold_full_nxt = 1'b0;
          end else if (accept) begin
            shift_nxt = data_in;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          if (div_cnt == LAST_DIV) begin
            div_nxt = '0;
            bit_nxt = bit_cnt + 1'b1;
          end else begin
            div_nxt = div_cnt + 1'b1;
          end
          if (accept) begin
            hold_nxt      = data_in;
            hold_full_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // serial_out is registered: precompute the bit that will be on the line after this edge.
    idx_nxt    = (MSB_FIRST != 0) ? (LAST_BIT - bit_nxt) : bit_nxt;
    serial_nxt = (state_nxt == SHIFT) && shift_nxt[idx_nxt];
  end

  // NOTE: sequential state uses non-blocking assignments only; the data registers are reset as
  // well so a discarded word can never leak out after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      hold_reg   <= '0;
      hold_full  <= 1'b0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      serial_out <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      hold_reg   <= hold_nxt;
      hold_full  <= hold_full_nxt;
      bit_cnt    <= bit_nxt;
      div_cnt    <= div_nxt;
      serial_out <= serial_nxt;
    end
  end

endmodule
